// File: rtl/c16_prog_loader_pkg.sv
// rtl/c16_prog_loader_pkg.sv - shared constants and state encoding for the c16 program loader
package c16_prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         ADDR_W_DEF    = 16;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_H  = 4'd1,
        ST_LEN_L  = 4'd2,
        ST_BASE_H = 4'd3,
        ST_BASE_L = 4'd4,
        ST_DAT_H  = 4'd5,
        ST_DAT_L  = 4'd6,
        ST_CSUM   = 4'd7
    } ld_state_e;

endpackage

// File: rtl/c16_prog_loader.sv
// rtl/c16_prog_loader.sv - framed byte stream to ram2 port A writer; holds the core until a good checksum
module c16_prog_loader
    import c16_prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int          ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       word_count
);

    ld_state_e         state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;
    logic [15:0]       word_count_q, word_count_d;

    logic              accept;
    logic [7:0]        sum_add;
    logic [15:0]       word_next;

    // The write cycle steals the input slot so one word costs three cycles.
    assign in_ready  = ~reset & ~mem_wren_q;
    assign accept    = in_valid & in_ready;
    assign sum_add   = sum_q + in_data;
    assign word_next = word_count_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        addr_d       = addr_q;
        hi_d         = hi_q;
        sum_d        = sum_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_wren_d   = 1'b0;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = 1'b0;
        load_error_d = load_error_q;
        word_count_d = word_count_q;

        if (accept) begin
            if (state_q != ST_IDLE) begin
                sum_d = sum_add;
            end
            case (state_q)
                ST_IDLE: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d      = ST_LEN_H;
                        sum_d        = 8'h00;
                        cpu_hold_d   = 1'b1;
                        word_count_d = 16'h0000;
                    end
                end
                ST_LEN_H: begin
                    len_d   = {in_data, len_q[7:0]};
                    state_d = ST_LEN_L;
                end
                ST_LEN_L: begin
                    len_d   = {len_q[15:8], in_data};
                    state_d = ST_BASE_H;
                end
                ST_BASE_H: begin
                    hi_d    = in_data;
                    state_d = ST_BASE_L;
                end
                ST_BASE_L: begin
                    addr_d  = ADDR_W'({hi_q, in_data});
                    state_d = (len_q == 16'h0000) ? ST_CSUM : ST_DAT_H;
                end
                ST_DAT_H: begin
                    hi_d    = in_data;
                    state_d = ST_DAT_L;
                end
                ST_DAT_L: begin
                    mem_wren_d   = 1'b1;
                    mem_addr_d   = addr_q;
                    mem_data_d   = {hi_q, in_data};
                    addr_d       = addr_q + ADDR_W'(1);
                    word_count_d = word_next;
                    state_d      = (word_next == len_q) ? ST_CSUM : ST_DAT_H;
                end
                ST_CSUM: begin
                    // Bad frames keep the core held; words already written stay in memory.
                    if (sum_add == 8'h00) begin
                        load_done_d  = 1'b1;
                        load_error_d = 1'b0;
                        cpu_hold_d   = 1'b0;
                    end else begin
                        load_error_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_q        <= 16'h0000;
            addr_q       <= '0;
            hi_q         <= 8'h00;
            sum_q        <= 8'h00;
            mem_addr_q   <= '0;
            mem_data_q   <= 16'h0000;
            mem_wren_q   <= 1'b0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            word_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            hi_q         <= hi_d;
            sum_q        <= sum_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_wren_q   <= mem_wren_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            word_count_q <= word_count_d;
        end
    end

    // Reset kills a write that is already registered, not just the next one.
    assign mem_wren   = mem_wren_q & ~reset;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_c16_prog_loader.sv
// tb/tb_c16_prog_loader.sv - randomized self-checking bench for c16_prog_loader
module tb_c16_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] word_count;

    c16_prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          done_seen = 0;
    int          gap_mode = 0;
    logic        hold_m = 1'b1;
    logic [15:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic [15:0] fixed_words[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_wren) begin
                check("write_expected", 32'(exp_addr.size() != 0), 32'd1);
                if (exp_addr.size() != 0) begin
                    check("wr_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
                    check("wr_data", 32'(mem_data), 32'(exp_data.pop_front()));
                end
            end
            if (load_done) done_seen++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int   gap;
        int   n;
        logic ok;
        logic acc;
        gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            acc = in_ready;
            @(negedge clk);
            ok = acc;
            n++;
        end
        check("byte_accepted", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wren", 32'(mem_wren), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_hold", 32'(cpu_hold), 32'd1);
        check("post_rst_error", 32'(load_error), 32'd0);
        check("post_rst_done", 32'(load_done), 32'd0);
        check("post_rst_wcount", 32'(word_count), 32'd0);
        check("post_rst_addr", 32'(mem_addr), 32'd0);
        check("post_rst_data", 32'(mem_data), 32'd0);
        hold_m = 1'b1;
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic run_frame(input int len, input logic [15:0] base, input bit good, input bit use_fixed);
        logic [7:0]  body[$];
        logic [7:0]  sum;
        logic [15:0] w;
        int          done0;
        body.push_back(8'(len >> 8));
        body.push_back(8'(len));
        body.push_back(base[15:8]);
        body.push_back(base[7:0]);
        for (int k = 0; k < len; k++) begin
            w = use_fixed ? fixed_words[k] : 16'($urandom);
            body.push_back(w[15:8]);
            body.push_back(w[7:0]);
            exp_addr.push_back(base + 16'(k));
            exp_data.push_back(w);
        end
        sum = 8'h00;
        foreach (body[i]) sum = sum + body[i];
        body.push_back(good ? 8'(-sum) : 8'(8'h01 - sum));
        done0 = done_seen;
        send_byte(8'hA5);
        check("hold_after_sync", 32'(cpu_hold), 32'd1);
        foreach (body[i]) send_byte(body[i]);
        check("done_pulse", 32'(load_done), 32'(good));
        check("error_flag", 32'(load_error), 32'(!good));
        check("hold_end", 32'(cpu_hold), 32'(!good));
        check("word_count", 32'(word_count), 32'(len));
        check("writes_drained", 32'(exp_addr.size()), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(load_done), 32'd0);
        check("done_count", 32'(done_seen - done0), 32'(good));
        hold_m = !good;
    endtask

    initial begin
        do_reset();

        fixed_words = '{16'h1234, 16'hABCD};
        run_frame(2, 16'h0010, 1'b1, 1'b1);
        run_frame(2, 16'h0010, 1'b0, 1'b1);
        run_frame(0, 16'h1234, 1'b1, 1'b0);
        run_frame(2, 16'hFFFF, 1'b1, 1'b0);

        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("garbage_hold", 32'(cpu_hold), 32'(hold_m));
        run_frame(3, 16'h0400, 1'b1, 1'b0);
        gap_mode = 1;
        send_byte(8'h00);
        send_byte(8'h5A);
        run_frame(3, 16'h0400, 1'b1, 1'b0);
        gap_mode = 0;

        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h20);
        exp_addr.push_back(16'h0020);
        exp_data.push_back(16'h1122);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        @(negedge clk);
        check("partial_drained", 32'(exp_addr.size()), 32'd0);
        do_reset();
        repeat (3) @(negedge clk);
        check("no_write_after_rst", 32'(exp_addr.size()), 32'd0);
        run_frame(2, 16'h0030, 1'b1, 1'b0);

        for (int f = 0; f < 8; f++) begin
            gap_mode = int'($urandom_range(0, 2));
            run_frame(int'($urandom_range(0, 6)), 16'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
